seg_display: RTL

SEG_DISPLAY -- requirements
Module: seg_display

---
 rtl/keyboard_pkg.sv | 104 ++++++++++
 rtl/seg_fifo.sv | 64 ++++++
 rtl/seg_display.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/keyboard_pkg.sv
// Shared constants and character decode for the display and keypad blocks:
// register map, status/control bit positions, character codes and 7-segment glyphs.
package keyboard_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned LANE_W     = 4;
    localparam int unsigned CHAR_W     = 8;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SCAN_W     = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CTRL_W     = 2;

    localparam logic [ADDR_W-1:0] ADDR_CHAR = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_STAU = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(2);

    localparam int unsigned STAU_EMPTY   = 0;
    localparam int unsigned STAU_FULL    = 1;
    localparam int unsigned STAU_OVF     = 2;
    localparam int unsigned CTRL_DISP_EN = 0;
    localparam int unsigned CTRL_IRQ_EN  = 1;

    localparam logic [CHAR_W-1:0] CH_0     = 8'h30;
    localparam logic [CHAR_W-1:0] CH_9     = 8'h39;
    localparam logic [CHAR_W-1:0] CH_SPACE = 8'h20;
    localparam logic [CHAR_W-1:0] CH_MINUS = 8'h2d;
    localparam logic [CHAR_W-1:0] CH_PLUS  = 8'h2b;
    localparam logic [CHAR_W-1:0] CH_DOT   = 8'h2e;
    localparam logic [CHAR_W-1:0] CH_CR    = 8'h0d;
    localparam logic [CHAR_W-1:0] CH_BS    = 8'h08;

    // Active-high segment glyphs, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 8'h00;
    localparam logic [SEG_W-1:0] GLYPH_MINUS = 8'h40;
    localparam logic [SEG_W-1:0] GLYPH_PLUS  = 8'h46;
    localparam logic [SEG_W-1:0] SEG_DP      = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_APPLY
    } eng_state_e;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_INSERT,
        ACT_DP,
        ACT_CLEAR,
        ACT_BACK
    } char_act_e;

    typedef struct packed {
        char_act_e          act;
        logic [SEG_W-1:0]   glyph;
    } char_dec_t;

    typedef struct packed {
        logic ovf;
        logic full;
        logic empty;
    } stau_t;

    function automatic logic [SEG_W-1:0] digit_glyph(input logic [3:0] d);
        logic [SEG_W-1:0] g;
        case (d)
            4'd0:    g = 8'h3f;
            4'd1:    g = 8'h06;
            4'd2:    g = 8'h5b;
            4'd3:    g = 8'h4f;
            4'd4:    g = 8'h66;
            4'd5:    g = 8'h6d;
            4'd6:    g = 8'h7d;
            4'd7:    g = 8'h07;
            4'd8:    g = 8'h7f;
            4'd9:    g = 8'h6f;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    function automatic char_dec_t decode_char(input logic [CHAR_W-1:0] c);
        char_dec_t d;
        d.act   = ACT_NONE;
        d.glyph = GLYPH_BLANK;
        if (c >= CH_0 && c <= CH_9) begin
            d.act   = ACT_INSERT;
            d.glyph = digit_glyph(4'(c - CH_0));
        end else begin
            case (c)
                CH_SPACE: d.act = ACT_INSERT;
                CH_MINUS: begin d.act = ACT_INSERT; d.glyph = GLYPH_MINUS; end
                CH_PLUS:  begin d.act = ACT_INSERT; d.glyph = GLYPH_PLUS;  end
                CH_DOT:   d.act = ACT_DP;
                CH_CR:    d.act = ACT_CLEAR;
                CH_BS:    d.act = ACT_BACK;
                default:  d.act = ACT_NONE;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/seg_fifo.sv
// Small synchronous FIFO holding characters waiting for the display engine.
// Pushes into a full FIFO and pops from an empty one are ignored.
module seg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c, do_pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push_c = push_i && !full_o;
    assign do_pop_c  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_c) mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/seg_display.sv
// Four-digit multiplexed 7-segment display controller with a character FIFO,
// a three-cycle apply engine, a status/control register bank and a drain interrupt.
module seg_display
    import keyboard_pkg::*;
#(
    parameter int unsigned SCAN_BITS = 13
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] addr,
    input  logic              enableIn,
    input  logic [LANE_W-1:0] enableOut,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              readyout,
    output logic              resp,
    output logic [SEG_W-1:0]  seg_pin,
    output logic [NUM_DIGITS-1:0] dig_pin,
    output logic              irq
);

    logic wr_c, rd_c, char_wr_c, ovf_set_c, ovf_clr_c;
    logic fifo_full, fifo_empty, pop_c;
    logic [CHAR_W-1:0] fifo_head;

    eng_state_e        state_q, state_d;
    logic [CHAR_W-1:0] char_q, char_d;
    logic [SEG_W-1:0]  buf_q [NUM_DIGITS];
    logic [SEG_W-1:0]  buf_d [NUM_DIGITS];
    char_dec_t         dec_c;

    logic              ovf_q, ovf_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CHAR_W-1:0] last_char_q, last_char_d;
    logic [DATA_W-1:0] dout_q, dout_d, rdata_c;
    stau_t             stau_c;

    logic [SCAN_BITS-1:0]  presc_q, presc_d;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  unused_c;

    assign wr_c      = enableIn && enableOut[0];
    assign rd_c      = !enableIn && (enableOut != '0);
    assign char_wr_c = wr_c && (addr == ADDR_CHAR);
    assign ovf_set_c = char_wr_c && fifo_full;
    assign ovf_clr_c = wr_c && (addr == ADDR_STAU) && dataIn[STAU_OVF];
    assign unused_c  = ^dataIn[DATA_W-1:CHAR_W];

    seg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (char_wr_c),
        .pop_i   (pop_c),
        .data_i  (dataIn[CHAR_W-1:0]),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Apply engine: fetch one character, then fold it into the digit buffer
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        char_d  = char_q;
        buf_d   = buf_q;
        dec_c   = decode_char(char_q);
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_POP;
            end
            ST_POP: begin
                pop_c   = 1'b1;
                char_d  = fifo_head;
                state_d = ST_APPLY;
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                case (dec_c.act)
                    ACT_INSERT: begin
                        for (int i = NUM_DIGITS - 1; i > 0; i--) buf_d[i] = buf_q[i-1];
                        buf_d[0] = dec_c.glyph;
                    end
                    ACT_DP:    buf_d[0] = buf_q[0] | SEG_DP;
                    ACT_CLEAR: for (int i = 0; i < NUM_DIGITS; i++) buf_d[i] = GLYPH_BLANK;
                    ACT_BACK: begin
                        for (int i = 0; i < NUM_DIGITS - 1; i++) buf_d[i] = buf_q[i+1];
                        buf_d[NUM_DIGITS-1] = GLYPH_BLANK;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            char_q  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= GLYPH_BLANK;
        end else begin
            state_q <= state_d;
            char_q  <= char_d;
            buf_q   <= buf_d;
        end
    end

    // Register bank; overflow set takes priority over a software clear
    always_comb begin
        ovf_d       = ovf_q;
        ctrl_d      = ctrl_q;
        last_char_d = last_char_q;
        if (ovf_set_c)      ovf_d = 1'b1;
        else if (ovf_clr_c) ovf_d = 1'b0;
        if (wr_c && (addr == ADDR_CTRL)) ctrl_d = dataIn[CTRL_W-1:0];
        if (char_wr_c) last_char_d = dataIn[CHAR_W-1:0];

        stau_c = '{ovf: ovf_q, full: fifo_full, empty: fifo_empty};
        case (addr)
            ADDR_CHAR: rdata_c = DATA_W'(last_char_q);
            ADDR_STAU: rdata_c = DATA_W'(stau_c);
            ADDR_CTRL: rdata_c = DATA_W'(ctrl_q);
            default:   rdata_c = '0;
        endcase
        dout_d = rd_c ? rdata_c : dout_q;
    end

    // Digit scan; pins are registered from next-state values so they track the buffer without lag
    always_comb begin
        presc_d = presc_q + SCAN_BITS'(1);
        scan_d  = (&presc_q) ? scan_q + SCAN_W'(1) : scan_q;
        seg_d   = '1;
        dig_d   = '1;
        if (ctrl_d[CTRL_DISP_EN]) begin
            seg_d = ~buf_d[scan_d];
            dig_d = ~(NUM_DIGITS'(1) << scan_d);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_q       <= 1'b0;
            ctrl_q      <= '0;
            last_char_q <= '0;
            dout_q      <= '0;
            presc_q     <= '0;
            scan_q      <= '0;
            seg_q       <= '1;
            dig_q       <= '1;
        end else begin
            ovf_q       <= ovf_d;
            ctrl_q      <= ctrl_d;
            last_char_q <= last_char_d;
            dout_q      <= dout_d;
            presc_q     <= presc_d;
            scan_q      <= scan_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
        end
    end

    assign dataOut  = dout_q;
    assign seg_pin  = seg_q;
    assign dig_pin  = dig_q;
    assign readyout = 1'b1;
    assign resp     = 1'b0;
    assign irq      = ctrl_q[CTRL_IRQ_EN] && fifo_empty && (state_q == ST_IDLE);

endmodule
